nds_flag_rr_sched: RTL and testbench

- Bank of NUM_REQ pending-event flags, each with set/clr semantics, plus a round-robin scheduler that hands them one at a time to a single consumer over a valid/ready handshake.
- Replaces ad-hoc per-source set/clr flag instances wherever several event sources share one service engine (e.g. replay, refill or writeback sequencers).
- Pending state and the scheduler pointer are held inside the block. The consumer only sees one ID at a time.

---
 rtl/nds_flag_rr_sched.sv | 132 +++++++++++++
 tb/tb_nds_flag_rr_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nds_flag_rr_sched.sv
// Pending-event flag bank with a round-robin scheduler feeding one consumer over valid/ready.
// An offer that is not accepted at once is locked and held stable until handshake or flush.
module nds_flag_rr_sched #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned ID_W         = 2,
   parameter bit          SET_OVER_CLR = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req_set,
   input  logic [NUM_REQ-1:0] req_mask,
   input  logic               flush,
   output logic [NUM_REQ-1:0] pend,
   output logic               out_valid,
   output logic [ID_W-1:0]    out_id,
   input  logic               out_ready
);

   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("NUM_REQ must be in 2..16");
   end
   if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
      $error("ID_W must equal clog2(NUM_REQ)");
   end

   typedef enum logic {StOpen, StLocked} lock_state_e;

   lock_state_e        state_q;
   logic [ID_W-1:0]    lock_id_q;
   logic [NUM_REQ-1:0] pend_q, pend_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] clr;
   logic               sel_found;
   logic [ID_W-1:0]    sel_id;
   logic               hs;

   assign elig = pend_q & ~req_mask;
   assign pend = pend_q;

   // Rotating priority search starting at ptr_q, wrapping modulo NUM_REQ.
   always_comb begin
      int unsigned idx;
      logic [ID_W-1:0] idx_id;
      sel_found = 1'b0;
      sel_id    = '0;
      idx       = 0;
      idx_id    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx    = (32'(ptr_q) + k) % NUM_REQ;
         idx_id = idx[ID_W-1:0];
         if (!sel_found && elig[idx_id]) begin
            sel_found = 1'b1;
            sel_id    = idx_id;
         end
      end
   end

   always_comb begin
      out_valid = 1'b0;
      out_id    = '0;
      if (state_q == StLocked) begin
         out_valid = 1'b1;
         out_id    = lock_id_q;
      end else if (sel_found) begin
         out_valid = 1'b1;
         out_id    = sel_id;
      end
   end

   assign hs = out_valid & out_ready;

   always_comb begin
      clr = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         clr[i] = hs && (out_id == ID_W'(i));
      end
   end

   always_comb begin
      pend_d = '0;
      if (!flush) begin
         if (SET_OVER_CLR) begin
            pend_d = req_set | (pend_q & ~clr);
         end else begin
            pend_d = (req_set | pend_q) & ~clr;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (hs) begin
         ptr_d = (out_id == ID_W'(NUM_REQ - 1)) ? '0 : out_id + ID_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q <= '0;
         ptr_q  <= '0;
      end else begin
         pend_q <= pend_d;
         ptr_q  <= ptr_d;
      end
   end

   // Lock tracker: freezes a stalled offer so the consumer never sees it change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StOpen;
         lock_id_q <= '0;
      end else begin
         case (state_q)
            StOpen: begin
               if (!flush && out_valid && !out_ready) begin
                  state_q   <= StLocked;
                  lock_id_q <= out_id;
               end
            end
            StLocked: begin
               if (hs || flush) begin
                  state_q <= StOpen;
               end
            end
            default: state_q <= StOpen;
         endcase
      end
   end

endmodule

// File: tb/tb_nds_flag_rr_sched.sv
// Table-driven bench for nds_flag_rr_sched: three instances cover the default build,
// clear-wins set handling and a non-power-of-two source count.
module tb_nds_flag_rr_sched;

   typedef struct packed {
      logic [1:0] dut;
      logic [3:0] set;
      logic [3:0] mask;
      logic       flush;
      logic       rdy;
      logic [3:0] pend;
      logic       valid;
      logic [1:0] id;
   } vec_t;

   typedef struct {
      logic [3:0] pend;
      logic       valid;
      logic [1:0] id;
   } exp_t;

   logic clk;
   logic reset_n;

   logic [3:0] set_a, mask_a, pend_a;
   logic       flush_a, rdy_a, valid_a;
   logic [1:0] id_a;

   logic [3:0] set_b, mask_b, pend_b;
   logic       flush_b, rdy_b, valid_b;
   logic [1:0] id_b;

   logic [2:0] set_c, mask_c, pend_c;
   logic       flush_c, rdy_c, valid_c;
   logic [1:0] id_c;

   int n_vec;
   int n_miss;

   vec_t tbl[$];
   exp_t sb[$];

   nds_flag_rr_sched #(.NUM_REQ(4), .ID_W(2), .SET_OVER_CLR(1'b1)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .req_set(set_a), .req_mask(mask_a), .flush(flush_a),
      .pend(pend_a), .out_valid(valid_a), .out_id(id_a), .out_ready(rdy_a)
   );

   nds_flag_rr_sched #(.NUM_REQ(4), .ID_W(2), .SET_OVER_CLR(1'b0)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .req_set(set_b), .req_mask(mask_b), .flush(flush_b),
      .pend(pend_b), .out_valid(valid_b), .out_id(id_b), .out_ready(rdy_b)
   );

   nds_flag_rr_sched #(.NUM_REQ(3), .ID_W(2), .SET_OVER_CLR(1'b1)) u_dut_c (
      .clk(clk), .reset_n(reset_n), .req_set(set_c), .req_mask(mask_c), .flush(flush_c),
      .pend(pend_c), .out_valid(valid_c), .out_id(id_c), .out_ready(rdy_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic [1:0] d, input logic [3:0] s, input logic [3:0] m,
                               input logic f, input logic r, input logic [3:0] p,
                               input logic v, input logic [1:0] i);
      vec_t t;
      t = '{dut: d, set: s, mask: m, flush: f, rdy: r, pend: p, valid: v, id: i};
      return t;
   endfunction

   task automatic chk(input string nm, input int row, input logic [3:0] act,
                      input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s row %0d: got %h, expected %h", nm, row, act, exp);
      end
   endtask

   task automatic idle_all();
      set_a = '0; mask_a = '0; flush_a = 1'b0; rdy_a = 1'b0;
      set_b = '0; mask_b = '0; flush_b = 1'b0; rdy_b = 1'b0;
      set_c = '0; mask_c = '0; flush_c = 1'b0; rdy_c = 1'b0;
   endtask

   task automatic apply(input vec_t v, input int row);
      exp_t e;
      logic [3:0] ap;
      logic       av;
      logic [1:0] ai;
      @(negedge clk);
      idle_all();
      case (v.dut)
         2'd0: begin set_a = v.set; mask_a = v.mask; flush_a = v.flush; rdy_a = v.rdy; end
         2'd1: begin set_b = v.set; mask_b = v.mask; flush_b = v.flush; rdy_b = v.rdy; end
         default: begin
            set_c = v.set[2:0]; mask_c = v.mask[2:0]; flush_c = v.flush; rdy_c = v.rdy;
         end
      endcase
      sb.push_back('{pend: v.pend, valid: v.valid, id: v.id});
      #1;
      case (v.dut)
         2'd0: begin ap = pend_a; av = valid_a; ai = id_a; end
         2'd1: begin ap = pend_b; av = valid_b; ai = id_b; end
         default: begin ap = {1'b0, pend_c}; av = valid_c; ai = id_c; end
      endcase
      e = sb.pop_front();
      chk("pend", row, ap, e.pend);
      chk("out_valid", row, {3'b0, av}, {3'b0, e.valid});
      chk("out_id", row, {2'b0, ai}, {2'b0, e.id});
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      reset_n = 1'b0;
      idle_all();

      //                dut  set      mask     fl rdy pend     v  id
      // Reset state and set-to-offer latency, then ptr=3 after granting id 2.
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0100, 1, 2));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0));
      // Round robin from ptr=3 over all four, then 1011.
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b1111, 1, 3));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0111, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0110, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0100, 1, 2));
      tbl.push_back(mk(0, 4'b1011, 4'b0000, 0, 1, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b1011, 1, 3));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0011, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0010, 1, 1));
      // Lock stability: offer of id 0 survives mask rising on it.
      tbl.push_back(mk(0, 4'b0011, 4'b0000, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0011, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 0, 4'b0011, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 0, 4'b0011, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 0, 4'b0011, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 1, 4'b0011, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 0, 4'b0010, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0010, 1, 1));
      // Set coincident with grant-clear re-arms.
      tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0010, 1, 1));
      // Flush while locked, ready low: ptr holds at 2.
      tbl.push_back(mk(0, 4'b1110, 4'b0000, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 4'b1110, 1, 2));
      tbl.push_back(mk(0, 4'b0001, 4'b0000, 1, 0, 4'b1110, 1, 2));
      // Flush while locked with ready high: grant completes, ptr -> 3.
      tbl.push_back(mk(0, 4'b1110, 4'b0000, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 4'b1110, 1, 2));
      tbl.push_back(mk(0, 4'b0001, 4'b0000, 1, 1, 4'b1110, 1, 2));
      tbl.push_back(mk(0, 4'b0101, 4'b0000, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0101, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0100, 1, 2));
      // Masked source stays pending, served once unmasked.
      tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 1, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0010, 0, 1, 4'b0010, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0010, 0, 1, 4'b0010, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0010, 1, 1));
      // Single source re-armed every cycle: continuous grants.
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 1, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 1, 4'b1000, 1, 3));
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 1, 4'b1000, 1, 3));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b1000, 1, 3));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0));
      // Clear-wins build: re-armed source granted every other cycle.
      tbl.push_back(mk(1, 4'b0010, 4'b0000, 0, 1, 4'b0000, 0, 0));
      tbl.push_back(mk(1, 4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 1));
      tbl.push_back(mk(1, 4'b0010, 4'b0000, 0, 1, 4'b0000, 0, 0));
      tbl.push_back(mk(1, 4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 1));
      tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 0));
      // Three sources: wrap from ptr=2 gives 2,0,1.
      tbl.push_back(mk(2, 4'b0010, 4'b0000, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(2, 4'b0000, 4'b0000, 0, 1, 4'b0010, 1, 1));
      tbl.push_back(mk(2, 4'b0111, 4'b0000, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(2, 4'b0000, 4'b0000, 0, 1, 4'b0111, 1, 2));
      tbl.push_back(mk(2, 4'b0000, 4'b0000, 0, 1, 4'b0011, 1, 0));
      tbl.push_back(mk(2, 4'b0000, 4'b0000, 0, 1, 4'b0010, 1, 1));
      tbl.push_back(mk(2, 4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(2, 4'b0000, 4'b0000, 0, 1, 4'b0001, 1, 0));
      tbl.push_back(mk(2, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0));

      // Outputs while held in reset.
      @(negedge clk);
      #1;
      chk("rst_pend", -1, pend_a, 4'b0000);
      chk("rst_valid", -1, {3'b0, valid_a}, 4'b0000);
      chk("rst_id", -1, {2'b0, id_a}, 4'b0000);
      @(negedge clk);
      reset_n = 1'b1;

      for (int r = 0; r < tbl.size(); r++) begin
         apply(tbl[r], r);
      end

      // Mid-operation reset: pending flags and ptr must not survive.
      @(negedge clk);
      idle_all();
      set_a = 4'b0100;
      @(negedge clk);
      set_a = 4'b0000;
      rdy_a = 1'b1;
      @(negedge clk);
      rdy_a = 1'b0;
      set_a = 4'b1111;
      @(negedge clk);
      set_a = 4'b0000;
      #1;
      chk("pre_rst_pend", -2, pend_a, 4'b1111);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_pend", -2, pend_a, 4'b0000);
      chk("mid_rst_valid", -2, {3'b0, valid_a}, 4'b0000);
      @(negedge clk);
      set_a = 4'b1111;
      #1;
      chk("rst_held_pend", -2, pend_a, 4'b0000);
      @(negedge clk);
      reset_n = 1'b1;
      set_a = 4'b1001;
      #1;
      chk("post_rst_pend", -2, pend_a, 4'b0000);
      @(negedge clk);
      set_a = 4'b0000;
      #1;
      chk("post_rst_pend2", -2, pend_a, 4'b1001);
      chk("post_rst_valid", -2, {3'b0, valid_a}, 4'b0001);
      chk("post_rst_id", -2, {2'b0, id_a}, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
